tybec_leaf_map_pipe: RTL
========================

Name: tybec_leaf_map_pipe

Overview:
Parametrised successor to the fixed two-input, fixed-latency leaf map node used by TyBEC-generated kernels. It takes NIN input streams, applies one integer operation selected at elaboration time, and pushes the result through a LAT-stage pipeline. Each stage has its own valid bit, so bubbles are tracked correctly and back-pressure is honoured without losing or duplicating data. It sits between upstream stream producers and downstream leaf/compound nodes, in place of hand-instantiated operator wrappers.

Parameters:
STREAMW, 34, data width of every input and output stream, in bits
NIN, 2, number of input streams (2..8)
LAT, 8, pipeline latency in cycles, from accept to ovalid (1..32)
OPMODE, 0, 0=sum of all inputs; 1=in0 minus sum of in1..in(NIN-1); 2=unsigned max of all inputs; 3=pass in0 through (other inputs only gate validity)

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  synchronous reset, active-high
ivalid  in  NIN  per-input valid; bit i belongs to input stream i
in_data  in  NIN*STREAMW  packed inputs; stream i occupies bits [i*STREAMW +: STREAMW]
iready  out  1  one ready signal shared by all inputs
out_data  out  STREAMW  result from the last pipeline stage
ovalid  out  1  out_data is valid
oready  in  1  downstream ready
busy  out  1  at least one stage holds valid data

Behaviour:
- Reset is synchronous and active-high on rst; clock is clk.
- Reset clears every stage valid bit and every stage data register to 0.
  - After reset: ovalid=0, out_data=0, busy=0.
  - iready is 1 from the first cycle after reset, provided the pipeline is empty.
- adv = ~v[LAT-1] | oready; this is the global advance enable.
- iready = adv. It is combinational from oready and v[LAT-1] only, never from ivalid.
- accept = &ivalid & adv. Partial valids are never accepted and do not consume a slot.
- When adv=1, on each clk edge:
  - v[0] <= accept; d[0] <= f(in_data).
  - For k=1..LAT-1: v[k] <= v[k-1]; d[k] <= d[k-1].
- When adv=0, all v and d registers hold.
- ovalid = v[LAT-1]; out_data = d[LAT-1].
- Output transfer occurs on a cycle where ovalid=1 and oready=1.
- Latency: an item accepted at edge t appears with ovalid=1 in the cycle after edge t+LAT-1, assuming no stall.
- LAT=1 gives a single registered output.
- Throughput: one item per cycle while oready=1.
- Bubble rule: bubbles are not collapsed. A stall freezes the whole pipeline, including empty stages.
- Arithmetic: all operations are modulo 2^STREAMW, with wrap-around on overflow and underflow.
  - OPMODE=2 compares inputs as unsigned.
  - The reduction is computed combinationally in front of stage 0.
- Simultaneous output transfer and input accept in the same cycle are legal and expected in steady state.
- Reset asserted mid-stream flushes all in-flight data. No output pulse is produced for flushed items.
- oready low with an empty last stage does not block the pipeline, because adv=1 when v[LAT-1]=0.
- busy = |v.

Optional Feature:
Macro TYBEC_LEAF_MAP_SAT_EN.
- Defined: OPMODE 0 and 1 treat operands as two's-complement signed.
  - The result saturates to 2^(STREAMW-1)-1 on positive overflow.
  - The result saturates to -2^(STREAMW-1) on negative overflow.
  - The accumulation uses STREAMW+clog2(NIN)+1 bits internally before clamping.
  - OPMODE 2 and 3 are unchanged.
- Undefined: pure modulo-2^STREAMW wrap, with no extra logic.

Test Plan:
1. Latency, default parameters (NIN=2, LAT=8, OPMODE=0): send in0=5, in1=7 with oready=1 held high -> out_data=12 and ovalid=1 exactly 8 cycles after accept, for exactly one cycle.
2. Partial valid: ivalid=2'b01 for 10 cycles, then 2'b11 with 3 and 4 -> exactly one output, value 7. No output is produced for the partial-valid cycles.
3. Back-pressure: stream 20 items, in0=i and in1=100, and drop oready for 5 cycles mid-stream -> 20 outputs of 100+i, in order, with none lost or duplicated. iready=0 throughout the stall.
4. Wrap vs saturation: STREAMW=8, OPMODE=0, in0=8'h7F, in1=8'h01.
   - Without the macro -> 8'h80.
   - With TYBEC_LEAF_MAP_SAT_EN -> 8'h7F.
   - OPMODE=1 with 8'h80 minus 8'h01, macro defined -> 8'h80.
5. Mid-stream reset: accept 4 items, assert rst for 1 cycle at cycle 3 -> no ovalid afterwards. busy=0 and out_data=0 the cycle after reset.
6. Other modes: NIN=4, OPMODE=2 with inputs {9,200,3,17} -> 200. LAT=1, OPMODE=3 with in0=0x2A -> 0x2A one cycle later.

Source files
------------

// File: rtl/tybec_leaf_map_pipe_if.sv
// Stream bundle for tybec_leaf_map_pipe: NIN input streams sharing one ready,
// one output stream, and a busy indicator.
// master = producer/consumer environment side, slave = the map node itself.
interface tybec_leaf_map_pipe_if #(
  parameter int STREAMW = 34,
  parameter int NIN     = 2
);
  logic [NIN-1:0]         ivalid;
  logic [NIN*STREAMW-1:0] in_data;
  logic                   iready;
  logic [STREAMW-1:0]     out_data;
  logic                   ovalid;
  logic                   oready;
  logic                   busy;

  modport master (
    output ivalid, in_data, oready,
    input  iready, out_data, ovalid, busy
  );

  modport slave (
    input  ivalid, in_data, oready,
    output iready, out_data, ovalid, busy
  );
endinterface

// File: rtl/tybec_leaf_map_pipe.sv
// Parametrised TyBEC leaf map node: reduces NIN input streams with one integer
// operation (OPMODE) and carries the result through a LAT-stage pipeline with a
// valid bit per stage. A stall freezes every stage, bubbles included.
// Optional macro TYBEC_LEAF_MAP_SAT_EN: OPMODE 0/1 become signed saturating;
// when undefined every mode wraps modulo 2^STREAMW.
module tybec_leaf_map_pipe #(
  parameter int STREAMW = 34,
  parameter int NIN     = 2,
  parameter int LAT     = 8,
  parameter int OPMODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  tybec_leaf_map_pipe_if.slave  io_bus
);

  logic [STREAMW-1:0] w_in [NIN];
  logic [STREAMW-1:0] w_base;
  logic [STREAMW-1:0] w_result;
  logic               w_adv;
  logic               w_accept;

  logic [LAT-1:0]     r_v;
  logic [STREAMW-1:0] r_d [LAT];

  genvar gi;
  for (gi = 0; gi < NIN; gi++) begin : g_unpack
    assign w_in[gi] = io_bus.in_data[gi*STREAMW +: STREAMW];
  end

  // The whole pipeline moves together whenever the last stage can drain.
  assign w_adv    = ~r_v[LAT-1] | io_bus.oready;
  assign w_accept = (&io_bus.ivalid) & w_adv;

  // Modulo-2^STREAMW reduction for every mode.
  always_comb begin
    w_base = '0;
    case (OPMODE)
      0: begin
        w_base = w_in[0];
        for (int i = 1; i < NIN; i++) w_base = w_base + w_in[i];
      end
      1: begin
        w_base = w_in[0];
        for (int i = 1; i < NIN; i++) w_base = w_base - w_in[i];
      end
      2: begin
        w_base = w_in[0];
        for (int i = 1; i < NIN; i++)
          if (w_in[i] > w_base) w_base = w_in[i];
      end
      default: w_base = w_in[0];
    endcase
  end

`ifdef TYBEC_LEAF_MAP_SAT_EN
  localparam int ACCW = STREAMW + $clog2(NIN) + 1;
  localparam logic signed [ACCW-1:0] SAT_HI =
    {{(ACCW-STREAMW+1){1'b0}}, {(STREAMW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_LO =
    {{(ACCW-STREAMW+1){1'b1}}, {(STREAMW-1){1'b0}}};

  logic signed [ACCW-1:0] w_acc;

  // Signed accumulate with headroom, then clamp; max/pass keep the wrap result.
  always_comb begin
    w_acc    = '0;
    w_result = w_base;
    if (OPMODE == 0 || OPMODE == 1) begin
      w_acc = ACCW'($signed(w_in[0]));
      for (int i = 1; i < NIN; i++) begin
        if (OPMODE == 0) w_acc = w_acc + ACCW'($signed(w_in[i]));
        else             w_acc = w_acc - ACCW'($signed(w_in[i]));
      end
      if (w_acc > SAT_HI)      w_result = SAT_HI[STREAMW-1:0];
      else if (w_acc < SAT_LO) w_result = SAT_LO[STREAMW-1:0];
      else                     w_result = w_acc[STREAMW-1:0];
    end
  end
`else
  assign w_result = w_base;
`endif

  // Stage registers: load/shift on advance, hold everything on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) begin
        r_v[k] <= 1'b0;
        r_d[k] <= '0;
      end
    end else if (w_adv) begin
      r_v[0] <= w_accept;
      r_d[0] <= w_result;
      for (int k = 1; k < LAT; k++) begin
        r_v[k] <= r_v[k-1];
        r_d[k] <= r_d[k-1];
      end
    end
  end

  assign io_bus.iready   = w_adv;
  assign io_bus.ovalid   = r_v[LAT-1];
  assign io_bus.out_data = r_d[LAT-1];
  assign io_bus.busy     = |r_v;

endmodule
